// File: rtl/md_unit_pkg.sv
// Shared CPU package: multiply/divide op codes, divider step count and the
// md_unit controller state type.
// Ports: none (types and constants only).
package md_unit_pkg;

    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } md_op_t;

    localparam int DIV_STEPS = 32;
    localparam int CNT_W     = $clog2(DIV_STEPS);

    // Controller states; prefixed so they do not collide with the op names.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_unit_div.sv
// Iterative restoring radix-2 divider datapath on unsigned magnitudes.
// Ports: load captures dividend/divisor; step advances one quotient bit per cycle;
//        quo_nxt/rem_nxt are the results the current step produces.
module div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quo_nxt,
    output logic [WIDTH-1:0] rem_nxt
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        // The quotient register doubles as the dividend shifter: its MSB feeds the
        // partial remainder while the new quotient bit enters at the LSB.
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        diff   = rem_sh - {1'b0, dvs_q};
        // Bit WIDTH of the difference is the borrow: set means "restore".
        if (diff[WIDTH]) begin
            quo_nxt = {quo_q[WIDTH-2:0], 1'b0};
            rem_nxt = rem_sh[WIDTH-1:0];
        end else begin
            quo_nxt = {quo_q[WIDTH-2:0], 1'b1};
            rem_nxt = diff[WIDTH-1:0];
        end

        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (step) begin
            rem_d = rem_nxt;
            quo_d = quo_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO: single-cycle MULT/MULTU/MTHI/MTLO,
// 33-cycle iterative DIV/DIVU with a stall (busy) request and a one-cycle DONE guard.
// Ports: clk/reset, start/op/flush from EX, a/b operands, busy stall, hi/lo results.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic               is_sdiv;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] s_prod, u_prod;
    logic               dc_load, dc_step;
    logic [WIDTH-1:0]   dc_quo, dc_rem;

    assign is_sdiv = (op == DIV);
    assign a_mag   = (is_sdiv && a[WIDTH-1]) ? -a : a;
    assign b_mag   = (is_sdiv && b[WIDTH-1]) ? -b : b;

    // Signed product from sign-extended operands: the low 2*WIDTH bits of the
    // unsigned product of the extended values equal the signed product.
    assign s_prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    assign u_prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    div_core #(.WIDTH(WIDTH)) u_div_core (
        .clk      (clk),
        .reset    (reset),
        .load     (dc_load),
        .step     (dc_step),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quo_nxt  (dc_quo),
        .rem_nxt  (dc_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        busy    = 1'b0;
        dc_load = 1'b0;
        dc_step = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (op)
                        MULT:  {hi_d, lo_d} = s_prod;
                        MULTU: {hi_d, lo_d} = u_prod;
                        MTHI:  hi_d = a;
                        MTLO:  lo_d = a;
                        DIV, DIVU: begin
                            busy    = 1'b1;
                            dc_load = 1'b1;
                            cnt_d   = CNT_W'(DIV_STEPS - 1);
                            qneg_d  = is_sdiv && (a[WIDTH-1] ^ b[WIDTH-1]);
                            rneg_d  = is_sdiv && a[WIDTH-1];
                            state_d = ST_DIV;
                        end
                        default: ;
                    endcase
                end
            end
            ST_DIV: begin
                if (flush) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    busy    = 1'b1;
                    dc_step = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    // Counter at zero marks the final step: commit its results directly.
                    if (cnt_q == '0) begin
                        lo_d    = qneg_q ? -dc_quo : dc_quo;
                        hi_d    = rneg_q ? -dc_rem : dc_rem;
                        state_d = ST_DONE;
                    end
                end
            end
            // One dead cycle so the still-asserted start of the held instruction
            // cannot re-issue the divide.
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    // Reference architectural state
    logic [31:0] m_hi, m_lo;

    md_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: results straight from the arithmetic definition.
    task automatic model_exec(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] am, bm, uq, ur;
        logic        sgn;
        sgn = (o == DIV);
        case (o)
            MULT: begin
                p = 64'(longint'($signed(x)) * longint'($signed(y)));
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MULTU: begin
                p = {32'd0, x} * {32'd0, y};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            MTHI: m_hi = x;
            MTLO: m_lo = x;
            DIV, DIVU: begin
                am = (sgn && x[31]) ? 32'd0 - x : x;
                bm = (sgn && y[31]) ? 32'd0 - y : y;
                uq = (bm == 0) ? 32'hFFFF_FFFF : am / bm;
                ur = (bm == 0) ? am : am % bm;
                if (sgn && (x[31] != y[31])) uq = 32'd0 - uq;
                if (sgn && x[31]) ur = 32'd0 - ur;
                m_hi = ur; m_lo = uq;
            end
            default: ;
        endcase
    endtask

    task automatic issue_single(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1; op = o; a = x; b = y;
        #1;
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        tick();
        start = 1'b0;
        model_exec(o, x, y);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        chk({tag, "_busy_after"}, 64'(busy), 64'(0));
    endtask

    // Divide with start held high through the whole stall and the DONE cycle.
    task automatic do_div(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int cycles;
        start = 1'b1; op = o; a = x; b = y;
        #1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 50) begin
            cycles++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(cycles), 64'(33));
        model_exec(o, x, y);
        chk({tag, "_hi"}, 64'(hi), 64'(m_hi));
        chk({tag, "_lo"}, 64'(lo), 64'(m_lo));
        chk({tag, "_done_busy"}, 64'(busy), 64'(0));
        tick();
        start = 1'b0;
        #1;
        chk({tag, "_no_reissue"}, 64'(busy), 64'(0));
        chk({tag, "_hi_hold"}, 64'(hi), 64'(m_hi));
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] rx, ry;

        reset = 1'b1; start = 1'b0; op = 3'd0; flush = 1'b0; a = '0; b = '0;
        m_hi = '0; m_lo = '0;
        #2;
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_hi", 64'(hi), 64'(0));
        chk("reset_lo", 64'(lo), 64'(0));
        tick();
        reset = 1'b0;
        tick();

        // Signed multiply of a negative by a small positive
        issue_single("mult_neg", MULT, 32'hFFFF_FFFE, 32'd3);
        chk("mult_neg_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);
        chk("mult_neg_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFA);
        issue_single("multu", MULTU, 32'hFFFF_FFFE, 32'd3);

        do_div("divu_100_7", DIVU, 32'd100, 32'd7);
        chk("divu_100_7_lo_const", 64'(lo), 64'd14);
        chk("divu_100_7_hi_const", 64'(hi), 64'd2);

        do_div("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFD);
        chk("div_m7_2_hi_const", 64'(hi), 64'h0000_0000_FFFF_FFFF);

        do_div("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_lo_const", 64'(lo), 64'h0000_0000_8000_0000);
        chk("div_ovf_hi_const", 64'(hi), 64'd0);

        do_div("divu_by0", DIVU, 32'd5, 32'd0);
        chk("divu_by0_lo_const", 64'(lo), 64'h0000_0000_FFFF_FFFF);
        chk("divu_by0_hi_const", 64'(hi), 64'd5);
        do_div("div_neg_by0", DIV, 32'hFFFF_FFFB, 32'd0);

        // Undefined op codes and flushed starts leave HI/LO alone
        issue_single("nop6", 3'd6, 32'h1234_5678, 32'h9ABC_DEF0);
        issue_single("nop7", 3'd7, 32'h1234_5678, 32'h9ABC_DEF0);
        start = 1'b1; op = MULT; a = 32'h7; b = 32'h9; flush = 1'b1;
        #1;
        chk("idle_flush_busy", 64'(busy), 64'(0));
        op = DIV;
        #1;
        chk("idle_flush_div_busy", 64'(busy), 64'(0));
        tick();
        start = 1'b0; flush = 1'b0;
        chk("idle_flush_hi", 64'(hi), 64'(m_hi));
        chk("idle_flush_lo", 64'(lo), 64'(m_lo));
        chk("idle_flush_nostart", 64'(busy), 64'(0));

        // Flush at DIV cycle 10
        issue_single("mthi", MTHI, 32'h11, 32'h0);
        issue_single("mtlo", MTLO, 32'h22, 32'h0);
        start = 1'b1; op = DIVU; a = 32'd1000; b = 32'd3;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("flush_pre_busy", 64'(busy), 64'(1));
        flush = 1'b1;
        #1;
        chk("flush_busy_drop", 64'(busy), 64'(0));
        tick();
        flush = 1'b0;
        chk("flush_hi", 64'(hi), 64'h11);
        chk("flush_lo", 64'(lo), 64'h22);
        chk("flush_idle", 64'(busy), 64'(0));
        do_div("after_flush", DIVU, 32'd1000, 32'd3);

        // Reset at DIV cycle 20
        issue_single("pre_rst_mthi", MTHI, 32'hDEAD_BEEF, 32'h0);
        start = 1'b1; op = DIV; a = 32'hFFFF_0000; b = 32'd77;
        tick();
        start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        reset = 1'b1;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'(0));
        chk("rst_mid_hi", 64'(hi), 64'(0));
        chk("rst_mid_lo", 64'(lo), 64'(0));
        m_hi = '0; m_lo = '0;
        tick();
        reset = 1'b0;
        tick();
        chk("rst_idle_busy", 64'(busy), 64'(0));
        chk("rst_idle_hi", 64'(hi), 64'(0));
        issue_single("rst_then_mult", MULT, 32'h8000_0001, 32'hFFFF_FFFD);

        // Randomised op mix against the reference model
        for (int n = 0; n < 24; n++) begin
            ro = 3'($urandom_range(0, 7));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0: ry = 32'd0;
                1: ry = 32'($urandom_range(1, 20));
                2: ry = 32'd0 - 32'($urandom_range(1, 20));
                default: ry = $urandom;
            endcase
            if (ro == DIV || ro == DIVU) do_div("rand_div", ro, rx, ry);
            else issue_single("rand_op", ro, rx, ry);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
